// File: rtl/multififo_arb_pkg.sv
// Shared types for the multififo push arbiter: FSM states and counter width.
package multififo_arb_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating first-set search: finds the first set request at or above i_ptr, wrapping.
// Purely combinational, zero latency.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_found,
  output logic [PW-1:0] o_idx
);

  int w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = (int'(i_ptr) + i) % N;
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = PW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/multififo_push_arbiter.sv
// Round-robin arbiter sharing one multififo push side among REQ_NUM requesters.
// Grants combinationally in the request cycle; an oversized head bundle stalls instead of being skipped.
module multififo_push_arbiter
  import multififo_arb_pkg::*;
#(
  parameter int REQ_NUM  = 2,
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [REQ_NUM-1:0]                       req_valid,
  input  logic [REQ_NUM-1:0][PORT_NUM-1:0]         req_lane_valid,
  input  logic [REQ_NUM-1:0][PORT_NUM-1:0][WIDTH-1:0] req_data,
  output logic [REQ_NUM-1:0]                       req_ready,
  input  logic [PORT_NUM-1:0]                      fifo_data_in_enable,
  input  logic                                     fifo_full,
  output logic [PORT_NUM-1:0][WIDTH-1:0]           fifo_data_in,
  output logic [PORT_NUM-1:0]                      fifo_data_in_valid,
  output logic                                     fifo_push,
  output logic                                     fifo_flush,
  input  logic                                     flush_req,
  output logic                                     busy_flush,
  output logic [CNT_W-1:0]                         push_lane_count,
  output logic [CNT_W-1:0]                         stall_count
);

  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  arb_state_e          r_state;
  logic [PW-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]    r_push_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_found;
  logic [PW-1:0]       w_idx;
  logic [PW-1:0]       w_ptr_nxt;
  logic [PORT_NUM-1:0] w_lanes;
  logic                w_fit;
  logic                w_idle;
  logic                w_push;
  logic                w_stall;
  logic [CNT_W-1:0]    w_pop;

  rr_priority_picker #(
    .N  (REQ_NUM),
    .PW (PW)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // All-or-nothing fit: every requested lane must be free and the FIFO not full.
  assign w_lanes   = req_lane_valid[w_idx];
  assign w_fit     = w_found && (|w_lanes) && ((w_lanes & ~fifo_data_in_enable) == '0) && !fifo_full;
  assign w_idle    = (r_state == ST_IDLE) && !rst;
  assign w_push    = w_idle && !flush_req && w_fit;
  assign w_stall   = w_idle && !flush_req && w_found && !w_fit;
  assign w_ptr_nxt = (int'(w_idx) == REQ_NUM - 1) ? '0 : w_idx + PW'(1);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      w_pop = w_pop + CNT_W'(fifo_data_in_valid[i]);
    end
  end

  always_comb begin
    req_ready          = '0;
    fifo_data_in       = '0;
    fifo_data_in_valid = '0;
    if (w_push) begin
      req_ready[w_idx]   = 1'b1;
      fifo_data_in       = req_data[w_idx];
      fifo_data_in_valid = w_lanes;
    end
  end

  assign fifo_push       = w_push;
  assign fifo_flush      = !rst && (r_state == ST_FLUSH);
  assign busy_flush      = !rst && (r_state != ST_IDLE);
  assign push_lane_count = rst ? '0 : r_push_cnt;
  assign stall_count     = rst ? '0 : r_stall_cnt;

  // Counters are cleared on entry to FLUSH so they already read zero during the flush cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_push_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_req) begin
            r_state     <= ST_FLUSH;
            r_rr_ptr    <= '0;
            r_push_cnt  <= '0;
            r_stall_cnt <= '0;
          end else begin
            if (w_push) begin
              r_rr_ptr   <= w_ptr_nxt;
              r_push_cnt <= r_push_cnt + w_pop;
            end
            if (w_stall) begin
              r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          r_state     <= ST_RECOVER;
          r_rr_ptr    <= '0;
          r_push_cnt  <= '0;
          r_stall_cnt <= '0;
        end
        ST_RECOVER: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multififo_push_arbiter.md
MULTIFIFO_PUSH_ARBITER -- requirements
Module: multififo_push_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 2, number of requesters sharing one multififo push side.
REQ-002 SHALL have parameter PORT_NUM, default 2, lanes per push; equals the FIFO port count.
REQ-003 SHALL have parameter WIDTH, default 32, data bits per lane.
REQ-004 SHALL have ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have requester-side ports, all indexed by requester r:
- req_valid  input  REQ_NUM  requester r has a bundle.
- req_lane_valid  input  [REQ_NUM][PORT_NUM]  lane mask per requester, contiguous from lane 0.
- req_data  input  [REQ_NUM][PORT_NUM][WIDTH]  lane data.
- req_ready  output  REQ_NUM  one-hot or zero; the bundle is accepted this cycle.
REQ-006 SHALL have FIFO-side ports:
- fifo_data_in_enable  input  PORT_NUM  free-lane mask from the FIFO.
- fifo_full  input  1  FIFO full.
- fifo_data_in  output  [PORT_NUM][WIDTH]  granted data.
- fifo_data_in_valid  output  PORT_NUM  granted lane mask.
- fifo_push  output  1  push strobe.
- fifo_flush  output  1  flush strobe.
REQ-007 SHALL have control and status ports:
- flush_req  input  1  request a FIFO flush.
- busy_flush  output  1  flush sequence in progress.
- push_lane_count  output  32  lanes pushed since reset or flush.
- stall_count  output  32  cycles with a valid winner not accepted.

Function
REQ-008 SHALL keep round-robin pointer rr_ptr (clog2(REQ_NUM) bits). The winner is the first r with req_valid, searching from rr_ptr upward modulo REQ_NUM.
REQ-009 SHALL treat the winner as fitting only if req_lane_valid[winner] & ~fifo_data_in_enable == 0, the mask is non-zero, and fifo_full == 0 (all-or-nothing).
REQ-010 SHALL NOT grant a lower-priority requester when the winner does not fit; the cycle is a stall, which prevents starvation of wide bundles.
REQ-011 In IDLE with a fitting winner, SHALL drive all of the following combinationally in the same cycle:
- fifo_push = 1
- fifo_data_in = req_data[winner]
- fifo_data_in_valid = req_lane_valid[winner]
- req_ready[winner] = 1
REQ-012 When no push occurs, fifo_push SHALL be 0, fifo_data_in_valid SHALL be 0, and all req_ready SHALL be 0.
REQ-013 On an accepted push, SHALL set rr_ptr to (winner + 1) mod REQ_NUM; otherwise rr_ptr holds.
REQ-014 On each push, push_lane_count SHALL add popcount(fifo_data_in_valid); the counter wraps at 2^32.
REQ-015 SHALL increment stall_count by 1 in each IDLE cycle where a winner exists but does not fit; the counter wraps at 2^32.
REQ-016 SHALL implement FSM IDLE -> FLUSH -> RECOVER -> IDLE.
- IDLE -> FLUSH when flush_req = 1.
- FLUSH -> RECOVER unconditionally.
- RECOVER -> IDLE unconditionally.
REQ-017 In FLUSH, SHALL assert fifo_flush = 1 for exactly one cycle and clear rr_ptr, push_lane_count and stall_count to 0.
REQ-018 In FLUSH and RECOVER, SHALL hold fifo_push = 0 and req_ready = 0, and SHALL assert busy_flush = 1.
REQ-019 When flush_req = 1 in IDLE, flush SHALL take priority: no push or grant that cycle.
REQ-020 SHALL ignore flush_req during FLUSH and RECOVER; flushes do not queue.
REQ-021 SHALL ignore req_lane_valid bits of non-winning requesters entirely.

Reset
REQ-022 On rst = 1, SHALL reset synchronously:
- state = IDLE
- rst SHALL override flush_req.
REQ-023 While rst = 1, all outputs SHALL be 0, including while a flush sequence is in progress.

Structure
REQ-024 The FSM state enum and the counter width constant (32) SHALL reside in shared package multififo_arb_pkg.
REQ-025 The rotating first-set search SHALL be sub-module rr_priority_picker (inputs: request vector, pointer; outputs: found flag, index).

Verification
REQ-026 The bench SHALL cover these directed scenarios:
1. Alternating grant: REQ_NUM = 2, both requesters valid with mask 2'b11, enable 2'b11, rr_ptr = 0 -> grants r0, r1, r0, r1 on consecutive cycles; push_lane_count = 8 after 4 cycles.
2. No skip: r0 mask 2'b11, r1 mask 2'b01, enable 2'b01, rr_ptr = 0 -> no push, no ready, stall_count increments each cycle. Enable -> 2'b11 -> r0 granted that cycle.
3. Full: fifo_full = 1 with valid requests -> fifo_push = 0; stall_count increases by 1 per cycle.
4. Flush precedence: flush_req = 1 in the same cycle as a fitting r1 request -> no push. Next cycle fifo_flush = 1 and busy_flush = 1; counters and rr_ptr are 0. Then RECOVER with busy_flush = 1, then IDLE grants r0 first.
5. Reset mid-flush: rst = 1 during RECOVER -> next cycle state is IDLE and all outputs are 0.
